// File: rtl/cache_ctrl_pkg.sv
// Shared types for the 2-way cache controller: FSM states and the layout
// of one way's line word, {valid, dirty, tag, block} from MSB down to LSB.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESPOND
    } state_t;

    // The per-set lru bit is kept outside the line word.
    localparam int BLK_LSB = 0;

    function automatic int tag_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int dirty_pos(input int tag_w, input int data_w);
        return data_w + tag_w;
    endfunction

    function automatic int valid_pos(input int tag_w, input int data_w);
        return data_w + tag_w + 1;
    endfunction

    function automatic int line_w(input int tag_w, input int data_w);
        return data_w + tag_w + 2;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way choice on a miss: the first invalid way (way0 first),
// otherwise the way named by the set's lru bit.
module cache_victim_sel
    import cache_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       lru,
    output logic       victim
);

    always_comb begin
        victim = lru;
        if (!valid[0])
            victim = 1'b0;
        else if (!valid[1])
            victim = 1'b1;
    end

endmodule

// File: rtl/cache_ctrl_2vias.sv
// 2-way set-associative write-back / write-allocate cache controller.
// Define CACHE_CTRL_STATS_EN to add saturating hit_count / miss_count outputs.
module cache_ctrl_2vias
    import cache_ctrl_pkg::*;
#(
    parameter int TAG_W  = 4,
    parameter int IDX_W  = 1,
    parameter int DATA_W = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [TAG_W-1:0]       req_tag,
    input  logic [IDX_W-1:0]       req_index,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_hit,
    output logic                   mem_rd_req,
    output logic                   mem_wr_req,
    output logic [TAG_W+IDX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);

    localparam int SETS = 1 << IDX_W;
    localparam int LW   = line_w(TAG_W, DATA_W);
    localparam int TL   = tag_lsb(DATA_W);
    localparam int DP   = dirty_pos(TAG_W, DATA_W);
    localparam int VP   = valid_pos(TAG_W, DATA_W);

    state_t state, state_next;

    logic [LW-1:0]     lines [SETS][2];
    logic [SETS-1:0]   lru;

    logic              cur_write;
    logic [TAG_W-1:0]  cur_tag;
    logic [IDX_W-1:0]  cur_index;
    logic [DATA_W-1:0] cur_wdata;
    logic              way;

    logic [LW-1:0]     line0, line1, hit_line, vic_line;
    logic              hit0, hit1, hit, victim, vic_dirty;
    logic [DATA_W-1:0] fill_data;

    assign line0     = lines[cur_index][0];
    assign line1     = lines[cur_index][1];
    assign hit0      = line0[VP] && (line0[TL +: TAG_W] == cur_tag);
    assign hit1      = line1[VP] && (line1[TL +: TAG_W] == cur_tag);
    assign hit       = hit0 || hit1;
    assign hit_line  = hit0 ? line0 : line1;
    assign vic_line  = victim ? line1 : line0;
    assign vic_dirty = vic_line[VP] && vic_line[DP];
    // Write-allocate: a write miss installs the CPU data, not the fetched block.
    assign fill_data = cur_write ? cur_wdata : mem_rdata;
    assign req_ready = (state == IDLE);

    cache_victim_sel u_victim (
        .valid  ({line1[VP], line0[VP]}),
        .lru    (lru[cur_index]),
        .victim (victim)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req_valid) state_next = LOOKUP;
            LOOKUP:    state_next = hit ? RESPOND : (vic_dirty ? WRITEBACK : FILL);
            WRITEBACK: if (mem_ack) state_next = FILL;
            FILL:      if (mem_ack) state_next = RESPOND;
            RESPOND:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lru        <= '0;
            cur_write  <= 1'b0;
            cur_tag    <= '0;
            cur_index  <= '0;
            cur_wdata  <= '0;
            way        <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_hit    <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < 2; w++)
                    lines[s][w] <= '0;
        end else begin
            state      <= state_next;
            rsp_valid  <= (state_next == RESPOND);
            mem_wr_req <= (state_next == WRITEBACK);
            mem_rd_req <= (state_next == FILL);
            case (state)
                IDLE: if (req_valid) begin
                    cur_write <= req_write;
                    cur_tag   <= req_tag;
                    cur_index <= req_index;
                    cur_wdata <= req_wdata;
                end
                LOOKUP: begin
                    rsp_hit <= hit;
                    if (hit) begin
                        lru[cur_index] <= hit0;
                        if (cur_write) begin
                            lines[cur_index][hit1 && !hit0][BLK_LSB +: DATA_W] <= cur_wdata;
                            lines[cur_index][hit1 && !hit0][DP]               <= 1'b1;
                            rsp_rdata <= cur_wdata;
                        end else begin
                            rsp_rdata <= hit_line[BLK_LSB +: DATA_W];
                        end
                    end else begin
                        way       <= victim;
                        mem_addr  <= vic_dirty ? {vic_line[TL +: TAG_W], cur_index}
                                               : {cur_tag, cur_index};
                        mem_wdata <= vic_line[BLK_LSB +: DATA_W];
                    end
                end
                WRITEBACK: if (mem_ack) mem_addr <= {cur_tag, cur_index};
                FILL: if (mem_ack) begin
                    lines[cur_index][way] <= {1'b1, cur_write, cur_tag, fill_data};
                    lru[cur_index]        <= ~way;
                    rsp_rdata             <= fill_data;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (!hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_2vias.sv
// Randomized bench for cache_ctrl_2vias against a per-set array model of the
// cache contents; a small memory responder acks with random (or zero) wait.
module tb_cache_ctrl_2vias;

    localparam int SETS = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [3:0] req_tag = '0;
    logic [0:0] req_index = '0;
    logic [4:0] req_wdata = '0;
    logic [4:0] mem_rdata = '0;
    logic       mem_ack = 1'b0;
    logic       req_ready, rsp_valid, rsp_hit, mem_rd_req, mem_wr_req;
    logic [4:0] rsp_rdata, mem_addr, mem_wdata;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_ctrl_2vias #(.TAG_W(4), .IDX_W(1), .DATA_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_tag    (req_tag),
        .req_index  (req_index),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_hit    (rsp_hit),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference contents of the cache, indexed [set][way].
    bit         m_valid [SETS][2];
    bit         m_dirty [SETS][2];
    logic [3:0] m_tag   [SETS][2];
    logic [4:0] m_data  [SETS][2];
    bit         m_lru   [SETS];
    int         m_hits, m_miss;

    bit         zero_wait = 1'b0;
    bit         t_hit, t_wb, t_fill;
    logic [4:0] t_rdata, t_wb_addr, t_wb_data, t_fill_addr;
    int         t_lat;

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic xact(input bit wr, input logic [3:0] tag, input logic [0:0] idx,
                        input logic [4:0] wd, input logic [4:0] fill);
        bit         hit0, hit1, hit, wb_exp, done;
        int         way, wait_cnt;
        logic [4:0] wb_addr_e, wb_data_e, exp_rdata;
        hit0 = m_valid[idx][0] && m_tag[idx][0] == tag;
        hit1 = m_valid[idx][1] && m_tag[idx][1] == tag;
        hit  = hit0 || hit1;
        if (hit0)                 way = 0;
        else if (hit1)            way = 1;
        else if (!m_valid[idx][0]) way = 0;
        else if (!m_valid[idx][1]) way = 1;
        else                      way = int'(m_lru[idx]);
        wb_exp    = !hit && m_valid[idx][way] && m_dirty[idx][way];
        wb_addr_e = {m_tag[idx][way], idx};
        wb_data_e = m_data[idx][way];

        @(negedge clock);
        req_valid = 1'b1;
        req_write = wr;
        req_tag   = tag;
        req_index = idx;
        req_wdata = wd;
        @(posedge clock);
        t_wb = 0; t_fill = 0; done = 0; t_lat = 0;
        wait_cnt = zero_wait ? 0 : $urandom_range(0, 3);
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = zero_wait ? 0 : $urandom_range(0, 3);
            end
            if (mem_wr_req && mem_rd_req) chk("rd_wr_excl", 1, 0);
            if (mem_wr_req && !t_wb) begin
                t_wb = 1; t_wb_addr = mem_addr; t_wb_data = mem_wdata;
                chk("wb_before_fill", t_fill, 0);
            end
            if (mem_rd_req && !t_fill) begin
                t_fill = 1; t_fill_addr = mem_addr;
            end
            if (mem_wr_req || mem_rd_req) begin
                if (wait_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_rd_req ? fill : 5'h1f;
                end else begin
                    wait_cnt--;
                end
            end else if (k == 1 && !zero_wait && $urandom_range(0, 1) == 1) begin
                // Stray ack during LOOKUP must be ignored.
                mem_ack   = 1'b1;
                mem_rdata = 5'h1e;
            end
            if (rsp_valid) begin
                done = 1; t_lat = k; t_rdata = rsp_rdata; t_hit = rsp_hit;
            end
        end
        if (!done) chk("rsp_timeout", 0, 1);
        mem_ack = 1'b0;
        @(negedge clock);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_after", req_ready, 1);

        if (hit) m_hits++;
        else begin
            m_miss++;
            m_valid[idx][way] = 1'b1;
            m_dirty[idx][way] = 1'b0;
            m_tag[idx][way]   = tag;
            m_data[idx][way]  = fill;
        end
        if (wr) begin
            m_data[idx][way]  = wd;
            m_dirty[idx][way] = 1'b1;
        end
        exp_rdata  = m_data[idx][way];
        m_lru[idx] = (way == 0);

        chk("hit", t_hit, hit);
        chk("rdata", t_rdata, exp_rdata);
        chk("wb_seen", t_wb, wb_exp);
        if (wb_exp) begin
            chk("wb_addr", t_wb_addr, wb_addr_e);
            chk("wb_data", t_wb_data, wb_data_e);
        end
        chk("fill_seen", t_fill, !hit);
        if (!hit) chk("fill_addr", t_fill_addr, {tag, idx});
        if (hit)  chk("hit_latency", t_lat, 2);
    endtask

    initial begin
        bit got_req;
        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rd_req", mem_rd_req, 0);
        chk("rst_wr_req", mem_wr_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", rsp_rdata, 0);
        reset = 1'b0;

        // Directed sequence.
        xact(0, 4'h8, 1'b0, 5'h00, 5'h03);
        chk("t1_fill_addr", t_fill_addr, 5'b1000_0);
        chk("t1_rdata", t_rdata, 5'h03);
        chk("t1_no_wb", t_wb, 0);
        xact(0, 4'h8, 1'b0, 5'h00, 5'h0a);
        chk("t2_hit", t_hit, 1);
        chk("t2_no_mem", t_fill, 0);
        xact(1, 4'hB, 1'b0, 5'h11, 5'h07);
        xact(0, 4'h2, 1'b0, 5'h00, 5'h09);
        chk("t3_no_wb", t_wb, 0);
        xact(0, 4'h3, 1'b0, 5'h00, 5'h01);
        chk("t4_wb", t_wb, 1);
        chk("t4_wb_addr", t_wb_addr, 5'b1011_0);
        chk("t4_wb_data", t_wb_data, 5'h11);
        chk("t4_fill_addr", t_fill_addr, 5'b0011_0);
`ifdef CACHE_CTRL_STATS_EN
        chk("t6_hit_count", hit_count, 1);
        chk("t6_miss_count", miss_count, 4);
`endif

        // Reset while a fill is outstanding.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_tag = 4'h5; req_index = 1'b0;
        @(posedge clock);
        got_req = 0;
        for (int k = 0; k < 10 && !got_req; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            got_req = mem_rd_req;
        end
        chk("t5_rd_req_up", got_req, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_rd_req_drop", mem_rd_req, 0);
        chk("t5_no_rsp", rsp_valid, 0);
        chk("t5_ready", req_ready, 1);
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        chk("t5_no_rsp_after", rsp_valid, 0);
        xact(0, 4'h2, 1'b0, 5'h00, 5'h0c);
        chk("t5_miss_after_rst", t_hit, 0);

        // Random traffic over a small tag space, then zero-wait memory.
        for (int i = 0; i < 200; i++) begin
            zero_wait = (i >= 140);
            xact(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom));
        end
`ifdef CACHE_CTRL_STATS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_miss);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
